// File: rtl/instr_encode.sv
// Packs MIPS R/I/J instruction fields into 32-bit words and writes them to consecutive
// instruction-memory addresses, one word per accepted field set.
module instr_encode #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        func,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              last,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              full,
    output logic              err
);

    localparam logic [1:0] FmtR   = 2'b00;
    localparam logic [1:0] FmtI   = 2'b01;
    localparam logic [1:0] FmtJ   = 2'b10;
    localparam logic [1:0] FmtBad = 2'b11;

    localparam logic [ADDR_W-1:0] LastAddr = '1;

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                err_q, err_d;
    logic                last_q, last_d;
    logic [31:0]         packed_word;

    always_comb begin
        packed_word = '0;
        unique case (fmt)
            FmtR:    packed_word = {opcode, rs, rt, rd, shamt, func};
            FmtI:    packed_word = {opcode, rs, rt, imm};
            FmtJ:    packed_word = {opcode, target};
            default: packed_word = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                // clear takes priority over a same-cycle handshake
                if (clear) begin
                    addr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (in_valid) begin
                    if (fmt == FmtBad) begin
                        err_d = 1'b1;
                        if (last) state_d = StDone;
                    end else begin
                        wdata_d = packed_word;
                        last_d  = last;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                count_d = count_q + (ADDR_W+1)'(1);
                if (addr_q == LastAddr) full_d = 1'b1;
                // Address never wraps: a full memory ends the load
                if (last_q || addr_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (clear) begin
                    addr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign in_ready   = (state_q == StIdle) && !rst;
    assign mem_we     = (state_q == StWrite);
    assign done       = (state_q == StDone);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign word_count = count_q;
    assign full       = full_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encode.sv
// Scoreboard bench for instr_encode: stimulus pushes expected writes, a negedge monitor
// pops and compares them whenever mem_we is seen.
module tb_instr_encode;

    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    fmt = 2'b00;
    logic [5:0]    opcode = '0;
    logic [4:0]    rs = '0;
    logic [4:0]    rt = '0;
    logic [4:0]    rd = '0;
    logic [4:0]    shamt = '0;
    logic [5:0]    func = '0;
    logic [15:0]   imm = '0;
    logic [25:0]   target = '0;
    logic          last = 1'b0;
    logic          clear = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;
    logic          done;
    logic          full;
    logic          err;

    instr_encode #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .func       (func),
        .imm        (imm),
        .target     (target),
        .last       (last),
        .clear      (clear),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .done       (done),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b0;
        end else begin
            if (mem_we) begin
                check("we_back_to_back", 32'(prev_we), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", mem_wdata, e.data);
                end
            end
            prev_we = mem_we;
        end
    end

    task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                        input logic l, input bit exp_we, input logic [AW-1:0] ea,
                        input logic [31:0] ed);
        int n;
        n = 0;
        @(negedge clk);
        fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; func = fn;
        imm = im; target = tg; last = l; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", n);
        end else if (exp_we) begin
            exp_q.push_back('{addr: ea, data: ed});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        #12;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_flags", {29'd0, done, full, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // 1: R-type, unused imm/target fields set to junk
        send(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF, 1'b0,
             1'b1, 2'd0, 32'h00221820);
        settle();
        check("t1_count", 32'(word_count), 32'd1);
        check("t1_ready", 32'(in_ready), 32'd1);
        do_clear();

        // 2: I then J with last
        send(2'b01, 6'h08, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3F, 16'h0005, 26'h3FFFFFF, 1'b0,
             1'b1, 2'd0, 32'h20220005);
        send(2'b10, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000100, 1'b1,
             1'b1, 2'd1, 32'h08000100);
        settle();
        check("t2_done", 32'(done), 32'd1);
        check("t2_count", 32'(word_count), 32'd2);
        check("t2_ready", 32'(in_ready), 32'd0);
        check("t2_full", 32'(full), 32'd0);
        do_clear();
        check("t2_clear_done", 32'(done), 32'd0);

        // 4: illegal format between two valid words
        send(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22, 16'h0000, 26'h0, 1'b0,
             1'b1, 2'd0, 32'h00221822);
        send(2'b11, 6'h3F, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'h1234, 26'h1234, 1'b0,
             1'b0, 2'd0, 32'h0);
        check("t4_err", 32'(err), 32'd1);
        check("t4_wdata_kept", mem_wdata, 32'h00221822);
        check("t4_ready", 32'(in_ready), 32'd1);
        send(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h24, 16'h0000, 26'h0, 1'b0,
             1'b1, 2'd1, 32'h00221824);
        settle();
        check("t4_count", 32'(word_count), 32'd2);
        // Illegal format with last ends the load without a write
        send(2'b11, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0, 1'b1,
             1'b0, 2'd0, 32'h0);
        check("t4_bad_last_done", 32'(done), 32'd1);
        check("t4_bad_last_count", 32'(word_count), 32'd2);
        check("t4_bad_last_addr", 32'(mem_addr), 32'd2);
        do_clear();
        check("t4_clear_err", 32'(err), 32'd0);

        // 6: backpressure, fields change during WRITE
        @(negedge clk);
        fmt = 2'b01; opcode = 6'h23; rs = 5'd29; rt = 5'd8; imm = 16'h0010; in_valid = 1'b1;
        exp_q.push_back('{addr: 2'd0, data: 32'h8FA80010});
        @(posedge clk);
        #1;
        fmt = 2'b10; opcode = 6'h03; target = 26'h3FFFFFF;
        check("t6_ready_in_write", 32'(in_ready), 32'd0);
        check("t6_we_in_write", 32'(mem_we), 32'd1);
        @(posedge clk);
        #1;
        fmt = 2'b01; opcode = 6'h2B; rs = 5'd29; rt = 5'd9; imm = 16'h0014;
        exp_q.push_back('{addr: 2'd1, data: 32'hAFA90014});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        settle();
        check("t6_count", 32'(word_count), 32'd2);

        // 5: asynchronous reset during WRITE
        send(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000100, 1'b0,
             1'b1, 2'd2, 32'h08000100);
        check("t5_we_before", 32'(mem_we), 32'd1);
        check("t5_addr_before", 32'(mem_addr), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        check("t5_we_dropped", 32'(mem_we), 32'd0);
        check("t5_addr", 32'(mem_addr), 32'd0);
        check("t5_wdata", mem_wdata, 32'd0);
        check("t5_count", 32'(word_count), 32'd0);
        check("t5_flags", {29'd0, done, full, err}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        send(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'h0, 1'b0,
             1'b1, 2'd0, 32'h00221820);
        settle();
        check("t5_count_after", 32'(word_count), 32'd1);
        do_clear();

        // 3: fill memory without last
        for (int i = 0; i < 4; i++) begin
            send(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'(i), 16'h0000, 26'h0, 1'b0,
                 1'b1, AW'(i), 32'h00221800 + 32'(i));
        end
        settle();
        check("t3_full", 32'(full), 32'd1);
        check("t3_done", 32'(done), 32'd1);
        check("t3_count", 32'(word_count), 32'd4);
        check("t3_addr_held", 32'(mem_addr), 32'd3);
        @(negedge clk);
        fmt = 2'b00; func = 6'h04; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_fifth_held_off", 32'(in_ready), 32'd0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        check("t3_clear_done", 32'(done), 32'd0);
        check("t3_clear_full", 32'(full), 32'd0);
        check("t3_clear_addr", 32'(mem_addr), 32'd0);
        check("t3_clear_count", 32'(word_count), 32'd0);
        check("t3_clear_ready", 32'(in_ready), 32'd1);

        // clear in IDLE beats a same-cycle handshake
        @(negedge clk);
        clear = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        check("idle_clear_ready", 32'(in_ready), 32'd1);
        repeat (2) settle();
        check("idle_clear_count", 32'(word_count), 32'd0);

        repeat (3) settle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
